// File: rtl/truxton2_snd_pkg.sv
// Shared types for the sound path: sample type, bridge state encoding and counter width.
package truxton2_snd_pkg;
  typedef logic signed [15:0] sample_t;
  typedef enum logic {ST_PRIME = 1'b0, ST_RUN = 1'b1} state_t;
  localparam int CNT_W = 8;
endpackage

// File: rtl/truxton2_sample_ram.sv
// DEPTH x DW sample store: one write port, one read port with a registered,
// resettable output that doubles as the bridge's held DOUT register.
module truxton2_sample_ram #(
  parameter int DW = 16,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read-before-write on a shared address: a full FIFO pushing and popping in
  // the same cycle must return the old (oldest) sample.
  always_ff @(posedge clk) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/truxton2_cen_sample_bridge.sv
// Crosses samples between two fractional clock-enable streams on one clock
// through a small primed FIFO with zero-order hold on underflow.
module truxton2_cen_sample_bridge
  import truxton2_snd_pkg::*;
#(
  parameter int DW    = 16,
  parameter int AW    = 3,
  parameter int PRIME = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             CEN_IN,
  input  logic [DW-1:0]    DIN,
  input  logic             DIN_VALID,
  input  logic             CEN_OUT,
  output logic [DW-1:0]    DOUT,
  output logic             DOUT_STB,
  output logic [AW:0]      LEVEL,
  output logic             RUNNING,
  output logic             OVF,
  output logic             UNF,
  output logic [CNT_W-1:0] DROP_CNT,
  output logic [CNT_W-1:0] UNF_CNT
);
  localparam int DEPTH = 2**AW;

  if (PRIME < 1 || PRIME > DEPTH) begin : g_prime_chk
    $error("PRIME must lie in 1..DEPTH");
  end

  state_t        state, state_nxt;
  logic [AW-1:0] wptr, rptr;
  logic          wr, rd, pop, accept, drop, empty_rd;

  always_comb begin
    wr        = CEN_IN & DIN_VALID;
    rd        = CEN_OUT & (state == ST_RUN);
    pop       = rd & (LEVEL != '0);
    empty_rd  = rd & (LEVEL == '0);
    // A full FIFO still accepts when a pop frees a slot in the same cycle.
    accept    = wr & ((LEVEL < (AW+1)'(DEPTH)) | pop);
    drop      = wr & ~accept;
    state_nxt = state;
    case (state)
      ST_PRIME: if (LEVEL >= (AW+1)'(PRIME)) state_nxt = ST_RUN;
      ST_RUN:   if (empty_rd)                state_nxt = ST_PRIME;
      default:                               state_nxt = ST_PRIME;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) state <= ST_PRIME;
    else       state <= state_nxt;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wptr     <= '0;
      rptr     <= '0;
      LEVEL    <= '0;
      DOUT_STB <= 1'b0;
      OVF      <= 1'b0;
      UNF      <= 1'b0;
      DROP_CNT <= '0;
      UNF_CNT  <= '0;
    end else begin
      if (accept) wptr <= wptr + 1'b1;
      if (pop)    rptr <= rptr + 1'b1;
      case ({accept, pop})
        2'b10:   LEVEL <= LEVEL + 1'b1;
        2'b01:   LEVEL <= LEVEL - 1'b1;
        default: LEVEL <= LEVEL;
      endcase
      DOUT_STB <= pop;
      OVF      <= drop;
      UNF      <= empty_rd;
      if (drop && DROP_CNT != '1)    DROP_CNT <= DROP_CNT + 1'b1;
      if (empty_rd && UNF_CNT != '1) UNF_CNT  <= UNF_CNT + 1'b1;
    end
  end

  assign RUNNING = (state == ST_RUN);

  truxton2_sample_ram #(.DW(DW), .AW(AW)) u_ram (
    .clk   (CLK),
    .rst   (RESET),
    .we    (accept),
    .waddr (wptr),
    .wdata (DIN),
    .re    (pop),
    .raddr (rptr),
    .rdata (DOUT)
  );
endmodule

// File: tb/tb_truxton2_cen_sample_bridge.sv
// Directed checks of the CEN sample bridge plus a fractional-rate scoreboard run.
module tb_truxton2_cen_sample_bridge;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cen_in = 1'b0, din_valid = 1'b0, cen_out = 1'b0;
  logic [15:0] din = '0;
  logic [15:0] dout;
  logic        dout_stb, running, ovf, unf;
  logic [3:0]  level;
  logic [7:0]  drop_cnt, unf_cnt;
  int          n_cmp = 0, n_err = 0;

  always #5 clk = ~clk;

  truxton2_cen_sample_bridge #(.DW(16), .AW(3), .PRIME(4)) dut (
    .CLK(clk), .RESET(rst), .CEN_IN(cen_in), .DIN(din), .DIN_VALID(din_valid),
    .CEN_OUT(cen_out), .DOUT(dout), .DOUT_STB(dout_stb), .LEVEL(level),
    .RUNNING(running), .OVF(ovf), .UNF(unf), .DROP_CNT(drop_cnt), .UNF_CNT(unf_cnt)
  );

  // One clock: apply inputs, take the edge, observe 1 time unit later.
  task automatic tick(input logic ci, input logic v, input logic [15:0] d, input logic co);
    cen_in = ci; din_valid = v; din = d; cen_out = co;
    @(posedge clk); #1;
    cen_in = 0; din_valid = 0; cen_out = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1; tick(0, 0, 0, 0); rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({dout, dout_stb, level, running, ovf, unf, drop_cnt, unf_cnt} !== '0) begin
      n_err++; $display("FAIL reset_state: got dout=%h stb=%b lvl=%0d run=%b ovf=%b unf=%b dc=%0d uc=%0d, want all 0",
                        dout, dout_stb, level, running, ovf, unf, drop_cnt, unf_cnt);
    end
  endtask

  task automatic test_prime();
    do_reset();
    for (int i = 1; i <= 4; i++) tick(1, 1, 16'(i), 0);
    n_cmp++; if (level !== 4 || running !== 0) begin n_err++;
      $display("FAIL prime_fill: got lvl=%0d run=%b, want 4/0", level, running); end
    tick(0, 0, 0, 0);
    n_cmp++; if (running !== 1) begin n_err++; $display("FAIL prime_run: got run=%b, want 1", running); end
    tick(0, 0, 0, 1);
    n_cmp++; if (dout !== 16'd1 || dout_stb !== 1 || level !== 3) begin n_err++;
      $display("FAIL first_read: got dout=%h stb=%b lvl=%0d, want 0001/1/3", dout, dout_stb, level); end
    tick(0, 0, 0, 0);
    n_cmp++; if (dout !== 16'd1 || dout_stb !== 0) begin n_err++;
      $display("FAIL hold_after_read: got dout=%h stb=%b, want 0001/0", dout, dout_stb); end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 8; i++) tick(1, 1, 16'(16'h10 + i), 0);
    tick(1, 1, 16'h7FFF, 0);
    n_cmp++; if (ovf !== 1 || level !== 8 || drop_cnt !== 1) begin n_err++;
      $display("FAIL ovf_pulse: got ovf=%b lvl=%0d dc=%0d, want 1/8/1", ovf, level, drop_cnt); end
    tick(0, 0, 0, 0);
    n_cmp++; if (ovf !== 0) begin n_err++; $display("FAIL ovf_single: got ovf=%b, want 0", ovf); end
    for (int i = 0; i < 8; i++) begin
      tick(0, 0, 0, 1);
      n_cmp++; if (dout !== 16'(16'h10 + i) || dout_stb !== 1) begin n_err++;
        $display("FAIL ovf_drain%0d: got dout=%h stb=%b, want %h/1", i, dout, dout_stb, 16'(16'h10 + i)); end
    end
    n_cmp++; if (level !== 0) begin n_err++; $display("FAIL ovf_empty: got lvl=%0d, want 0", level); end
  endtask

  task automatic test_full_simul();
    do_reset();
    for (int i = 0; i < 8; i++) tick(1, 1, 16'(16'h20 + i), 0);
    tick(1, 1, 16'h0055, 1);
    n_cmp++; if (level !== 8 || ovf !== 0 || dout !== 16'h20 || dout_stb !== 1) begin n_err++;
      $display("FAIL full_simul: got lvl=%0d ovf=%b dout=%h stb=%b, want 8/0/0020/1", level, ovf, dout, dout_stb); end
    for (int i = 1; i < 9; i++) begin
      tick(0, 0, 0, 1);
      n_cmp++; if (dout !== ((i == 8) ? 16'h0055 : 16'(16'h20 + i))) begin n_err++;
        $display("FAIL full_drain%0d: got dout=%h", i, dout); end
    end
  endtask

  // Continues from the drained FIFO left by test_full_simul.
  task automatic test_underflow();
    tick(0, 0, 0, 1);
    n_cmp++; if (unf !== 1 || unf_cnt !== 1 || running !== 0 || dout !== 16'h0055 || dout_stb !== 0) begin n_err++;
      $display("FAIL unf_pulse: got unf=%b uc=%0d run=%b dout=%h stb=%b, want 1/1/0/0055/0",
               unf, unf_cnt, running, dout, dout_stb); end
    tick(0, 0, 0, 1);
    n_cmp++; if (unf !== 0 || unf_cnt !== 1 || dout !== 16'h0055) begin n_err++;
      $display("FAIL prime_cen_out: got unf=%b uc=%0d dout=%h, want 0/1/0055", unf, unf_cnt, dout); end
    // Simultaneous write and read into an empty FIFO while running.
    do_reset();
    for (int i = 0; i < 4; i++) tick(1, 1, 16'(16'h30 + i), 0);
    tick(0, 0, 0, 0);
    for (int i = 0; i < 4; i++) tick(0, 0, 0, 1);
    tick(1, 1, 16'h0099, 1);
    n_cmp++; if (level !== 1 || unf !== 1 || running !== 0 || dout_stb !== 0 || dout !== 16'h33) begin n_err++;
      $display("FAIL empty_simul: got lvl=%0d unf=%b run=%b stb=%b dout=%h, want 1/1/0/0/0033",
               level, unf, running, dout_stb, dout); end
  endtask

  task automatic test_reset_midway();
    do_reset();
    for (int i = 0; i < 6; i++) tick(1, 1, 16'(16'h40 + i), 0);
    tick(0, 0, 0, 1);
    n_cmp++; if (level !== 5 || dout !== 16'h40) begin n_err++;
      $display("FAIL pre_reset: got lvl=%0d dout=%h, want 5/0040", level, dout); end
    rst = 1'b1; tick(1, 1, 16'h1234, 1); rst = 1'b0;
    n_cmp++;
    if ({dout, dout_stb, level, running, ovf, unf, drop_cnt, unf_cnt} !== '0) begin n_err++;
      $display("FAIL reset_midway: got dout=%h lvl=%0d run=%b, want all 0", dout, level, running); end
    for (int i = 0; i < 8; i++) tick(1, 1, 16'(i), 0);
    for (int i = 0; i < 300; i++) tick(1, 1, 16'hDEAD, 0);
    n_cmp++; if (drop_cnt !== 8'd255 || ovf !== 1 || level !== 8) begin n_err++;
      $display("FAIL drop_saturate: got dc=%0d ovf=%b lvl=%0d, want 255/1/8", drop_cnt, ovf, level); end
  endtask

  // CEN_IN ~ 4 MHz (1/24 of CLK96), CEN_OUT ~ 3.375 MHz (9/256 of CLK96).
  task automatic test_fractional();
    logic [15:0] q[$];
    logic [15:0] exp_d;
    int acc_in = 0, acc_out = 0, mlev = 0, nprint = 0, npop = 0;
    logic mrun = 0, ci, co, v, rd, pp, ac;
    logic [15:0] d;
    do_reset();
    for (int c = 0; c < 40000; c++) begin
      acc_in++;        ci = (acc_in == 24);  if (ci) acc_in = 0;
      acc_out += 9;    co = (acc_out >= 256); if (co) acc_out -= 256;
      v  = ($urandom_range(0, 7) != 0);
      d  = 16'($urandom);
      rd = co && mrun;
      pp = rd && (mlev != 0);
      ac = ci && v && (mlev < 8 || pp);
      exp_d = 16'h0;
      if (pp) exp_d = q.pop_front();
      if (ac) q.push_back(d);
      if (!mrun && mlev >= 4) mrun = 1;
      else if (rd && mlev == 0) mrun = 0;
      mlev = mlev + (ac ? 1 : 0) - (pp ? 1 : 0);
      tick(ci, v, d, co);
      n_cmp++;
      if (dout_stb !== pp || (pp && dout !== exp_d) || level !== 4'(mlev) || level > 8) begin
        n_err++;
        if (nprint < 10) begin
          nprint++;
          $display("FAIL frac_c%0d: got stb=%b dout=%h lvl=%0d, want stb=%b dout=%h lvl=%0d",
                   c, dout_stb, dout, level, pp, exp_d, mlev);
        end
      end
      if (pp) npop++;
    end
    n_cmp++; if (npop < 1000) begin n_err++; $display("FAIL frac_activity: got pops=%0d, want >=1000", npop); end
  endtask

  initial begin
    test_reset();
    test_prime();
    test_overflow();
    test_full_simul();
    test_underflow();
    test_reset_midway();
    test_fractional();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
